// File: rtl/instruction_prefetch_queue_pkg.sv
// Shared defaults and width helpers for the instruction prefetch queue.
package iq_pkg;

   localparam int IQ_WIDTH_DEFAULT = 16;
   localparam int IQ_DEPTH_DEFAULT = 4;

   function automatic int iq_ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int iq_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/instruction_prefetch_queue_if.sv
// Fetch/decoder control and status bundle of the prefetch queue.
interface instruction_prefetch_queue_if
   import iq_pkg::*;
#(
   parameter int WIDTH = IQ_WIDTH_DEFAULT,
   parameter int DEPTH = IQ_DEPTH_DEFAULT
);
   logic                        iq_load;
   logic [WIDTH-1:0]            in_value;
   logic                        iq_next;
   logic                        iq_flush;
   logic                        iq_enOut;
   logic                        iq_valid;
   logic                        iq_full;
   logic [iq_cnt_w(DEPTH)-1:0]  iq_count;

   modport master (
      output iq_load, in_value, iq_next, iq_flush, iq_enOut,
      input  iq_valid, iq_full, iq_count
   );

   modport slave (
      input  iq_load, in_value, iq_next, iq_flush, iq_enOut,
      output iq_valid, iq_full, iq_count
   );
endinterface

// File: rtl/instruction_prefetch_queue_storage.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
module iq_storage
   import iq_pkg::*;
#(
   parameter int WIDTH = IQ_WIDTH_DEFAULT,
   parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       we,
   input  logic [iq_ptr_w(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]           wdata,
   input  logic [iq_ptr_w(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]           rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem <= '{default: '0};
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch FIFO between program-memory fetch and the decoder,
// with flush/reload on jumps and a tri-state head-word output.
module instruction_prefetch_queue
   import iq_pkg::*;
#(
   parameter int WIDTH = IQ_WIDTH_DEFAULT,
   parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   instruction_prefetch_queue_if.slave iq,
   output wire  [WIDTH-1:0]       out_value
);
   localparam int PW = iq_ptr_w(DEPTH);
   localparam int CW = iq_cnt_w(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    count;
   logic             is_full;
   logic             is_valid;
   logic             pop_ok;
   logic             push_ok;
   logic             we;
   logic [PW-1:0]    waddr;
   logic [WIDTH-1:0] head;

   assign is_full  = (count == FULL_CNT);
   assign is_valid = (count != '0);

   // A pop frees the slot the same cycle, so push-on-full is accepted only alongside it.
   assign pop_ok  = iq.iq_next && is_valid && !iq.iq_flush;
   assign push_ok = iq.iq_load && (!is_full || pop_ok);

   // Flush with load reloads entry 0 so the jump target is at the head next cycle.
   assign we    = iq.iq_flush ? iq.iq_load : push_ok;
   assign waddr = iq.iq_flush ? '0 : wr_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (iq.iq_flush) begin
         rd_ptr <= '0;
         wr_ptr <= PW'(iq.iq_load);
         count  <= CW'(iq.iq_load);
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

   iq_storage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_storage (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .waddr (waddr),
      .wdata (iq.in_value),
      .raddr (rd_ptr),
      .rdata (head)
   );

   assign iq.iq_valid = is_valid;
   assign iq.iq_full  = is_full;
   assign iq.iq_count = count;

   assign out_value = !iq.iq_enOut ? {WIDTH{1'bz}} : (is_valid ? head : '0);
endmodule

// File: doc/instruction_prefetch_queue.md
# instruction_prefetch_queue

Parametrised successor to the single-word instruction register: a DEPTH-entry FIFO of WIDTH-bit instruction words between the program-memory fetch path and the decoder. The fetch side pushes words whenever space exists; the decoder reads the head word through a tri-state output and advances the queue. A flush empties the queue on jumps, and can reload it with the target word in the same cycle.

## Interface
- WIDTH, 16, instruction word width in bits
- DEPTH, 4, queue entries; power of two, ≥2
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- iq_load  input  1  push in_value at the tail this cycle
- in_value  input  WIDTH  word from program memory
- iq_next  input  1  pop the head word (decoder consumed it)
- iq_flush  input  1  discard all stored words
- iq_enOut  input  1  drive head word onto out_value
- out_value  output  WIDTH  head word when driven, else high-Z
- iq_valid  output  1  queue holds ≥1 word
- iq_full  output  1  queue holds DEPTH words
- iq_count  output  $clog2(DEPTH+1)  number of stored words

## Operation
- Storage: DEPTH×WIDTH registers, read pointer rd_ptr and write pointer wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH; count register tracks occupancy.
- Push accepted when iq_load=1 and (not full, or full with an accepted pop the same cycle); a push on full without a pop is dropped, with state unchanged.
- Pop accepted when iq_next=1 and iq_valid=1; a pop on empty is ignored.
- Simultaneous accepted push and pop: both pointers advance, count unchanged; legal at any occupancy including full. On empty, a pop is not accepted, so only the push takes effect.
- Flush: pointers and count return to 0, and iq_next is ignored. If iq_load=1 in the same cycle, in_value is written to entry 0 and count becomes 1, giving jump-target reload with no bubble.
- out_value = storage[rd_ptr] when iq_enOut=1 and iq_valid=1; high-Z when iq_enOut=0; all-zero when iq_enOut=1 and empty.
- Storage contents are never cleared by flush; only pointers and count change.

## Timing
- Reset (rst_n low, asynchronous): rd_ptr=0, wr_ptr=0, count=0, so iq_valid=0, iq_full=0, iq_count=0, and out_value is high-Z or zero according to iq_enOut. Storage is reset to 0.
- Reset asserted mid-operation takes effect immediately, without waiting for a clock edge. Deassertion is sampled and the queue is usable from the next rising edge.
- All state updates occur on the rising edge of clk. iq_valid, iq_full and iq_count are registered-state decodes, valid right after the edge.
- Push-to-head latency into an empty queue: 1 cycle. The word pushed at edge N appears on out_value after edge N.
- out_value, iq_valid, iq_full and iq_count are combinational from registers; there is no combinational path from iq_load or iq_next to any output.
- Pop at edge N: the next word appears on out_value after edge N.
- Priority within one edge: reset > flush (+ optional reload) > push/pop.

## Structure
- Shared package iq_pkg: IQ_WIDTH_DEFAULT=16, IQ_DEPTH_DEFAULT=4, and the derived pointer/count width functions.
- One sub-module iq_storage: DEPTH×WIDTH register file with one write port (we, waddr, wdata) and one asynchronous read port (raddr → rdata). Pointer, count and tri-state logic stay in the top level.

## Test plan
- Reset, then iq_enOut=1 with no pushes → iq_valid=0, iq_count=0, out_value=16'h0000. Set iq_enOut=0 → out_value=16'hzzzz.
- Push 16'hFDFD, then 16'hBABA → out_value=16'hFDFD, iq_count=2. Pop → out_value=16'hBABA, iq_count=1. Pop → iq_valid=0.
- Fill with 16'h0001..16'h0004 → iq_full=1. Push 16'h0005 alone → dropped, iq_count=4. Push 16'h0005 with a pop → head=16'h0002, still full. Drain four pops → 16'h0002, 16'h0003, 16'h0004, 16'h0005 in order (pointer wrap).
- Hold three words, assert iq_flush with iq_load=1 and in_value=16'hC0DE → after the edge iq_count=1 and out_value=16'hC0DE. Assert iq_flush alone → iq_count=0.
- Pop on empty, and push+pop on empty with in_value=16'hAAAA → count stays 0, then becomes 1 with head 16'hAAAA, with no underflow.
- Pull rst_n low between clock edges with three words stored → iq_count=0 immediately; the next push after release appears at the head after one edge.
